// File: rtl/tt_rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant for a decoded AND-OR mux.
// A grant is held until the downstream consumer takes the beat. A granted
// requester can keep ownership across beats by raising its lock bit. After an
// unlocked beat, the requester that was just served is skipped for one cycle.
module tt_rr_onehot_arbiter #(
    parameter int REQ_WIDTH = 4,
    parameter int IDX_WIDTH = $clog2(REQ_WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [REQ_WIDTH-1:0] i_req,
    input  logic [REQ_WIDTH-1:0] i_lock,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [REQ_WIDTH-1:0] o_gnt,
    output logic [IDX_WIDTH-1:0] o_gnt_idx,
    output logic                 o_xfer
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    logic [IDX_WIDTH-1:0] ptr_after;
    logic [REQ_WIDTH-1:0] arb_idle;
    logic [REQ_WIDTH-1:0] arb_next;

    // Returns the first set bit of mask, searching from ptr upward and
    // wrapping at REQ_WIDTH. The result is one-hot, or zero if mask is empty.
    function automatic logic [REQ_WIDTH-1:0] arb(input logic [REQ_WIDTH-1:0] mask,
                                                 input logic [IDX_WIDTH-1:0] ptr);
        logic found;
        int   j;
        arb   = '0;
        found = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            j = int'(ptr) + i;
            if (j >= REQ_WIDTH) j = j - REQ_WIDTH;
            if (!found && mask[j[IDX_WIDTH-1:0]]) begin
                arb[j[IDX_WIDTH-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    endfunction

    // Converts a one-hot (or zero) vector to its binary index.
    function automatic logic [IDX_WIDTH-1:0] enc(input logic [REQ_WIDTH-1:0] oh);
        enc = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (oh[i]) enc = enc | IDX_WIDTH'(i);
        end
    endfunction

    // Updates the state register. Reset drops any grant or lock at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic. After an unlocked beat, the pointer moves to the slot
    // just past the served requester, and that requester is masked out.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        ptr_after = (idx_q == IDX_WIDTH'(REQ_WIDTH - 1)) ? '0 : idx_q + 1'b1;
        arb_idle  = arb(i_req, ptr_q);
        arb_next  = arb(i_req & ~gnt_q, ptr_after);
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = arb_idle;
                    idx_d   = enc(arb_idle);
                end
            end
            ST_GRANT: begin
                if (o_xfer && !i_lock[idx_q]) begin
                    ptr_d = ptr_after;
                    if (|arb_next) begin
                        gnt_d = arb_next;
                        idx_d = enc(arb_next);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Drives the outputs. The grant comes straight from registers; the
    // transfer strobe is the only combinational output.
    always_comb begin
        o_valid   = (state_q == ST_GRANT);
        o_gnt     = gnt_q;
        o_gnt_idx = idx_q;
        o_xfer    = (state_q == ST_GRANT) && i_ready;
    end

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(gnt_q));
    a_req_held: assert property (@(posedge i_clk) disable iff (i_reset)
        o_valid |-> |(i_req & gnt_q));
    a_valid_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (o_valid && !i_ready) |=> o_valid);
`endif

endmodule

// File: tb/tb_tt_rr_onehot_arbiter.sv
`timescale 1ns/1ps
module tb_tt_rr_onehot_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_req;
    logic [3:0] i_lock;
    logic       i_ready;
    logic       o_valid;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_idx;
    logic       o_xfer;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] idx;
    } exp_t;

    exp_t exp_q[$];

    tt_rr_onehot_arbiter #(.REQ_WIDTH(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req),
        .i_lock    (i_lock),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_gnt     (o_gnt),
        .o_gnt_idx (o_gnt_idx),
        .o_xfer    (o_xfer)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] idx);
        exp_q.push_back('{g, idx});
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted beat must match the next expected beat.
    always @(negedge i_clk) begin
        if (!i_reset && o_xfer) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_xfer: got gnt=%b expected no transfer", o_gnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("xfer_gnt", o_gnt, e.gnt);
                check("xfer_idx", 4'(o_gnt_idx), e.idx);
            end
        end
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        i_reset = 1'b1;
        i_req   = '0;
        i_lock  = '0;
        i_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 4'(o_valid), 4'd0);
        check("rst_gnt", o_gnt, 4'b0000);
        i_reset = 1'b0;

        // Idle with no requests
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge i_clk);
            check("idle_valid", 4'(o_valid), 4'd0);
            check("idle_gnt", o_gnt, 4'b0000);
            check("idle_idx", 4'(o_gnt_idx), 4'd0);
        end

        // Single requester: bubble between unlocked beats, then wrap-around from ptr=3
        tick();
        i_req = 4'b0100; i_ready = 1'b1;
        push(4'b0100, 4'd2);
        push(4'b0100, 4'd2);
        tick();
        @(negedge i_clk);
        check("single_latency_valid", 4'(o_valid), 4'd1);
        tick();
        @(negedge i_clk);
        check("single_bubble_valid", 4'(o_valid), 4'd0);
        tick();
        tick();
        i_req = 4'b0011;
        push(4'b0001, 4'd0);
        push(4'b0010, 4'd1);
        tick();
        tick();
        i_req = 4'b0010;
        tick();
        i_req = 4'b0000;
        tick();

        // Async reset while granted; pointer must return to 0
        i_req = 4'b0001; i_ready = 1'b0;
        tick();
        @(negedge i_clk);
        check("pre_rst_gnt", o_gnt, 4'b0001);
        #2;
        i_reset = 1'b1;
        i_req   = 4'b0000;
        #1;
        check("async_rst_gnt", o_gnt, 4'b0000);
        check("async_rst_valid", 4'(o_valid), 4'd0);
        check("async_rst_idx", 4'(o_gnt_idx), 4'd0);
        tick();
        tick();
        i_reset = 1'b0;
        i_req = 4'b0110; i_ready = 1'b1;
        push(4'b0010, 4'd1);
        push(4'b0100, 4'd2);
        tick();
        tick();
        i_req = 4'b0100;
        tick();
        i_req = 4'b0000;
        tick();

        // Fair rotation from reset with all requesting
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_req = 4'b1111; i_ready = 1'b1;
        push(4'b0001, 4'd0);
        push(4'b0010, 4'd1);
        push(4'b0100, 4'd2);
        push(4'b1000, 4'd3);
        push(4'b0001, 4'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) i_req = 4'b0001;
            @(negedge i_clk);
            check("rotate_no_bubble", 4'(o_xfer), 4'd1);
        end
        tick();
        i_req = 4'b0000;
        tick();

        // Backpressure
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_req = 4'b0011; i_ready = 1'b0;
        push(4'b0001, 4'd0);
        push(4'b0010, 4'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge i_clk);
            check("bp_gnt_stable", o_gnt, 4'b0001);
            check("bp_no_xfer", 4'(o_xfer), 4'd0);
        end
        tick();
        i_ready = 1'b1;
        tick();
        i_req = 4'b0010;
        tick();
        i_req = 4'b0000;
        tick();

        // Locked burst: three locked transfers, then unlocked
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_req = 4'b1010; i_lock = 4'b0010; i_ready = 1'b1;
        push(4'b0010, 4'd1);
        push(4'b0010, 4'd1);
        push(4'b0010, 4'd1);
        push(4'b0010, 4'd1);
        push(4'b1000, 4'd3);
        tick();
        tick();
        tick();
        tick();
        i_lock = 4'b0000;
        tick();
        i_req = 4'b1000;
        tick();
        i_req = 4'b0000;
        tick();
        tick();
        @(negedge i_clk);
        check("end_idle_valid", 4'(o_valid), 4'd0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_rr_onehot_arbiter.md
Name: tt_rr_onehot_arbiter

Overview:
- Round-robin arbiter producing a registered, strictly one-hot select vector plus valid/ready handshake toward a downstream decoded (AND-OR) mux and its consumer.
- Sits directly upstream of the decoded mux: o_gnt drives the mux select, o_valid qualifies the mux output.
- Supports locked multi-beat grants, so a requester can keep ownership across consecutive transfers.

Parameters:
REQ_WIDTH, 4, number of requesters (≥2); width of the one-hot grant.
IDX_WIDTH, $clog2(REQ_WIDTH), width of the binary grant index.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_req  input  REQ_WIDTH  per-requester request; held high until that requester's transfer.
i_lock  input  REQ_WIDTH  per-requester lock; sampled only for the granted requester at transfer.
i_ready  input  1  downstream accepts the current beat.
o_valid  output  1  grant is active; downstream mux output is valid.
o_gnt  output  REQ_WIDTH  registered one-hot select (all-zero when o_valid=0).
o_gnt_idx  output  IDX_WIDTH  binary index of o_gnt bit; 0 when idle.
o_xfer  output  1  combinational o_valid & i_ready (transfer strobe).

Behaviour:
- Reset (asynchronous assert, synchronous release): o_valid=0, o_gnt=0, o_gnt_idx=0, state=IDLE, priority pointer ptr=0.
- Transfer: o_xfer=1 in any cycle with o_valid=1 and i_ready=1.
- Arbitration function ARB(mask): first set bit of mask searching ptr, ptr+1, …, REQ_WIDTH-1, 0, …, ptr-1 (wrap-around). Result is one-hot or zero.
- States:
  - IDLE: o_valid=0.
    - If |i_req, load o_gnt=ARB(i_req), o_valid=1, go to GRANT.
    - Latency is 1 cycle from request to o_valid. There is no combinational path from i_req to o_gnt.
  - GRANT: o_valid=1; o_gnt and o_gnt_idx are stable until a transfer.
    - No transfer: hold everything. The grant is kept even if the granted i_req drops (protocol violation; the SIM assertion flags it).
    - Transfer with i_lock[o_gnt_idx]=1: keep o_gnt, stay in GRANT, ptr unchanged (locked burst).
    - Transfer with lock=0: ptr ← (o_gnt_idx+1) mod REQ_WIDTH. Next grant = ARB_new(i_req & ~o_gnt), where ARB_new uses the updated ptr.
      - Result nonzero: load it, stay in GRANT (back-to-back, no bubble).
      - Result zero: o_valid←0, o_gnt←0, go to IDLE.
    - The just-served requester is excluded for one cycle. A lone continuous requester therefore sees one bubble cycle between unlocked beats.
- Invariants: o_gnt is one-hot when o_valid=1 and zero otherwise. o_gnt_idx always encodes o_gnt.
- Simultaneous requests are resolved purely by ptr order; no requester waits more than REQ_WIDTH-1 unlocked grants.
- Reset mid-burst: the grant and lock are dropped immediately; the pointer returns to 0.
- SIM-only assertions:
  - o_gnt is onehot0.
  - A granted i_req stays high until its transfer.
  - o_valid is stable while i_ready=0.

Test Plan:
- Reset, i_req=4'b0000 → o_valid=0, o_gnt=0, o_gnt_idx=0 indefinitely. Assert i_reset while in GRANT → o_gnt=0 in the same cycle (asynchronous).
- Single requester: i_req=4'b0100, i_ready=1, lock=0 → next cycle o_gnt=4'b0100, idx=2, o_xfer=1. Following cycle o_valid=0 (bubble), then regrant; ptr=3.
- Fair rotation: i_req=4'b1111 held, i_ready=1, no lock, from reset → grant sequence 0001,0010,0100,1000,0001 on consecutive cycles with no bubbles.
- Backpressure: i_req=4'b0011, i_ready=0 for 5 cycles → o_gnt=4'b0001 stable throughout. i_ready=1 → transfer, next o_gnt=4'b0010.
- Locked burst: i_req=4'b1010, i_lock[1]=1 for 3 transfers, then 0 → o_gnt=4'b0010 for 4 beats, then 4'b1000. ptr advances only after the unlocked beat.
- Wrap-around: ptr=3 (after granting idx 2), i_req=4'b0011 → grant idx 0, then idx 1.
